// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   VAL_W      operand / result width
//   KEY_*      keypad codes above the digit range 0x00-0x0F
//   alu_op_t   ALU operation encoding driven on alu_op
//   calc_state_t sequencer state, also exported on disp_state
package calc_pkg;

   localparam int VAL_W = 16;

   localparam logic [4:0] KEY_ADD = 5'h10;
   localparam logic [4:0] KEY_MUL = 5'h11;
   localparam logic [4:0] KEY_AND = 5'h12;
   localparam logic [4:0] KEY_EXE = 5'h13;
   localparam logic [4:0] KEY_SUB = 5'h14;
   localparam logic [4:0] KEY_OR  = 5'h15;
   localparam logic [4:0] KEY_CE  = 5'h16;
   localparam logic [4:0] KEY_CLR = 5'h17;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_MUL = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_ENTER_A  = 2'd0,
      ST_ENTER_B  = 2'd1,
      ST_WAIT_ALU = 2'd2,
      ST_RESULT   = 2'd3
   } calc_state_t;

   function automatic logic is_op_key(input logic [4:0] code);
      return (code == KEY_ADD) || (code == KEY_MUL) || (code == KEY_AND) ||
             (code == KEY_SUB) || (code == KEY_OR);
   endfunction

   function automatic alu_op_t key_to_op(input logic [4:0] code);
      alu_op_t op;
      case (code)
         KEY_SUB: op = ALU_SUB;
         KEY_MUL: op = ALU_MUL;
         KEY_AND: op = ALU_AND;
         KEY_OR:  op = ALU_OR;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/digit_accum.sv
// digit_accum: shared shift-accumulate for operand entry plus the per-operand
// digit counter. The parent muxes the active operand onto cur_val and writes
// acc_val back when accept is high.
// Ports:
//   clk, rst       clock, async active-low reset
//   clr            zero the digit counter (wins over accept)
//   digit_valid    a digit key is presented for an operand that may take it
//   dec_mode       1 = decimal (v*10+d), 0 = hex ((v<<4)|d)
//   digit          digit value 0x0-0xF
//   cur_val        current value of the active operand
//   acc_val        accumulated value, truncated to VAL_W
//   accept         digit is legal for the mode and the counter has room
module digit_accum
   import calc_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             digit_valid,
   input  logic             dec_mode,
   input  logic [3:0]       digit,
   input  logic [VAL_W-1:0] cur_val,
   output logic [VAL_W-1:0] acc_val,
   output logic             accept
);

   localparam int CW = $clog2(DIGITS + 1);

   logic [CW-1:0] cnt;

   assign accept = digit_valid && !(dec_mode && (digit > 4'd9)) && (cnt < CW'(DIGITS));

   assign acc_val = dec_mode ? (cur_val * VAL_W'(10) + {{(VAL_W-4){1'b0}}, digit})
                             : {cur_val[VAL_W-5:0], digit};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand entry and ALU launch sequencer.
// Optional feature macro: CALC_CHAIN_EN -- operator key in RESULT reuses the
// displayed result as op_a and continues with op_b entry.
// Ports:
//   clk, rst                 clock, async active-low reset
//   key_valid, key_code      keypad strobe and code
//   dec_mode                 1 = decimal entry, 0 = hex entry
//   alu_done, alu_result     ALU completion strobe and result
//   op_a, op_b, alu_op       operands and operation presented to the ALU
//   alu_start                one-cycle ALU launch pulse
//   restriction              mirrors dec_mode for the cursor grid
//   disp_val, disp_state     display value and current state
//   err                      sticky ALU timeout flag
//
// state        | meaning
// ST_ENTER_A   | entering first operand, display op_a
// ST_ENTER_B   | entering second operand, display op_b, EXE launches ALU
// ST_WAIT_ALU  | waiting for alu_done with timeout, only CLR accepted
// ST_RESULT    | showing ALU result (or 0xFFFF after timeout)
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int ALU_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [4:0]       key_code,
   input  logic             dec_mode,
   input  logic             alu_done,
   input  logic [VAL_W-1:0] alu_result,
   output logic [VAL_W-1:0] op_a,
   output logic [VAL_W-1:0] op_b,
   output logic [2:0]       alu_op,
   output logic             alu_start,
   output logic             restriction,
   output logic [VAL_W-1:0] disp_val,
   output logic [1:0]       disp_state,
   output logic             err
);

   localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

   calc_state_t      state;
   logic [TMR_W-1:0] tmr;

   logic             key_live;
   logic             is_clr;
   logic             is_digit;
   logic             is_op;
   logic             is_exe;
   logic             is_ce;
   logic             entering;
   logic             chain_go;
   logic             acc_clr;
   logic             digit_valid;
   logic [VAL_W-1:0] cur_val;
   logic [VAL_W-1:0] acc_val;
   logic             acc_accept;

   // CLR always wins; every other key is dropped when alu_done lands with it.
   assign is_clr   = key_valid && (key_code == KEY_CLR);
   assign key_live = key_valid && !alu_done;
   assign is_digit = key_live && !key_code[4];
   assign is_op    = key_live && is_op_key(key_code);
   assign is_exe   = key_live && (key_code == KEY_EXE);
   assign is_ce    = key_live && (key_code == KEY_CE);

   assign entering = (state == ST_ENTER_A) || (state == ST_ENTER_B);

`ifdef CALC_CHAIN_EN
   assign chain_go = is_op && (state == ST_RESULT) && !err;
`else
   assign chain_go = 1'b0;
`endif

   // The digit counter is already zero in RESULT (cleared on EXE), so a digit
   // there both restarts op_a and counts as its first digit.
   assign acc_clr = is_clr
                 || (is_ce  && entering)
                 || (is_op  && (state == ST_ENTER_A))
                 || (is_exe && (state == ST_ENTER_B))
                 || chain_go;

   assign digit_valid = is_digit && (state != ST_WAIT_ALU);

   always_comb begin
      cur_val = '0;
      case (state)
         ST_ENTER_A: cur_val = op_a;
         ST_ENTER_B: cur_val = op_b;
         default:    cur_val = '0;
      endcase
   end

   digit_accum #(
      .DIGITS (DIGITS)
   ) u_digit_accum (
      .clk         (clk),
      .rst         (rst),
      .clr         (acc_clr),
      .digit_valid (digit_valid),
      .dec_mode    (dec_mode),
      .digit       (key_code[3:0]),
      .cur_val     (cur_val),
      .acc_val     (acc_val),
      .accept      (acc_accept)
   );

   assign restriction = dec_mode;
   assign disp_state  = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_ENTER_A;
         op_a      <= '0;
         op_b      <= '0;
         alu_op    <= ALU_ADD;
         alu_start <= 1'b0;
         disp_val  <= '0;
         err       <= 1'b0;
         tmr       <= '0;
      end else begin
         alu_start <= 1'b0;
         if (is_clr) begin
            state    <= ST_ENTER_A;
            op_a     <= '0;
            op_b     <= '0;
            alu_op   <= ALU_ADD;
            disp_val <= '0;
            err      <= 1'b0;
            tmr      <= '0;
         end else begin
            case (state)
               ST_ENTER_A: begin
                  if (acc_accept) begin
                     op_a     <= acc_val;
                     disp_val <= acc_val;
                  end else if (is_ce) begin
                     op_a     <= '0;
                     disp_val <= '0;
                  end else if (is_op) begin
                     alu_op   <= key_to_op(key_code);
                     op_b     <= '0;
                     disp_val <= '0;
                     state    <= ST_ENTER_B;
                  end
               end
               ST_ENTER_B: begin
                  if (acc_accept) begin
                     op_b     <= acc_val;
                     disp_val <= acc_val;
                  end else if (is_ce) begin
                     op_b     <= '0;
                     disp_val <= '0;
                  end else if (is_op) begin
                     alu_op <= key_to_op(key_code);
                  end else if (is_exe) begin
                     alu_start <= 1'b1;
                     tmr       <= TMR_W'(ALU_TIMEOUT - 1);
                     state     <= ST_WAIT_ALU;
                  end
               end
               ST_WAIT_ALU: begin
                  // Down-counter reaches zero on the last allowed cycle;
                  // alu_done on that same cycle still counts as in time.
                  if (alu_done) begin
                     disp_val <= alu_result;
                     state    <= ST_RESULT;
                  end else if (tmr == '0) begin
                     err      <= 1'b1;
                     disp_val <= '1;
                     state    <= ST_RESULT;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               ST_RESULT: begin
                  if (acc_accept) begin
                     op_a     <= acc_val;
                     op_b     <= '0;
                     err      <= 1'b0;
                     disp_val <= acc_val;
                     state    <= ST_ENTER_A;
                  end else if (chain_go) begin
                     op_a     <= disp_val;
                     alu_op   <= key_to_op(key_code);
                     op_b     <= '0;
                     disp_val <= '0;
                     state    <= ST_ENTER_B;
                  end
               end
               default: state <= ST_ENTER_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scenarios plus randomized key/ALU traffic,
// checked against a per-cycle behavioural calculator model.
`timescale 1ns/1ps
module tb_calc_sequencer;

   localparam int DIGITS      = 4;
   localparam int ALU_TIMEOUT = 255;

   localparam int K_ADD = 16, K_MUL = 17, K_AND = 18, K_EXE = 19;
   localparam int K_SUB = 20, K_OR  = 21, K_CE  = 22, K_CLR = 23;
   localparam int S_A = 0, S_B = 1, S_WAIT = 2, S_RES = 3;

`ifdef CALC_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [4:0]  key_code = '0;
   logic        dec_mode = 1'b0;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic [15:0] op_a, op_b, disp_val;
   logic [2:0]  alu_op;
   logic        alu_start, restriction, err;
   logic [1:0]  disp_state;

   calc_sequencer #(
      .DIGITS      (DIGITS),
      .ALU_TIMEOUT (ALU_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .dec_mode    (dec_mode),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_op      (alu_op),
      .alu_start   (alu_start),
      .restriction (restriction),
      .disp_val    (disp_val),
      .disp_state  (disp_state),
      .err         (err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // calculator model
   int m_state, m_a, m_b, m_op, m_disp, m_cnt, m_wait;
   bit m_err, m_start;

   function automatic int op_of(input int kc);
      case (kc)
         K_ADD:   return 0;
         K_SUB:   return 1;
         K_MUL:   return 2;
         K_AND:   return 3;
         K_OR:    return 4;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_state = S_A; m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
      m_cnt = 0; m_wait = 0; m_err = 0; m_start = 0;
   endtask

   task automatic model_cycle(input bit kv, input int kc, input bit dm,
                              input bit done, input int res);
      bit live;
      int op;
      m_start = 0;
      if (kv && kc == K_CLR) begin
         model_reset();
         return;
      end
      live = kv && !done;
      op   = op_of(kc);
      if (m_state == S_WAIT) begin
         if (done) begin
            m_disp = res; m_state = S_RES;
         end else begin
            m_wait++;
            if (m_wait >= ALU_TIMEOUT) begin
               m_err = 1; m_disp = 65535; m_state = S_RES;
            end
         end
      end else if (live) begin
         if (kc < 16) begin
            if (!(dm && kc > 9) && m_cnt < DIGITS) begin
               if (m_state == S_A) begin
                  m_a = dm ? (m_a * 10 + kc) % 65536 : (m_a * 16 + kc) % 65536;
                  m_disp = m_a; m_cnt++;
               end else if (m_state == S_B) begin
                  m_b = dm ? (m_b * 10 + kc) % 65536 : (m_b * 16 + kc) % 65536;
                  m_disp = m_b; m_cnt++;
               end else begin
                  m_a = kc; m_b = 0; m_err = 0; m_disp = kc; m_cnt = 1; m_state = S_A;
               end
            end
         end else if (op >= 0) begin
            if (m_state == S_A) begin
               m_op = op; m_b = 0; m_disp = 0; m_cnt = 0; m_state = S_B;
            end else if (m_state == S_B) begin
               m_op = op;
            end else if (CHAIN && !m_err) begin
               m_a = m_disp; m_op = op; m_b = 0; m_disp = 0; m_cnt = 0; m_state = S_B;
            end
         end else if (kc == K_EXE) begin
            if (m_state == S_B) begin
               m_start = 1; m_wait = 0; m_cnt = 0; m_state = S_WAIT;
            end
         end else if (kc == K_CE) begin
            if (m_state == S_A) begin
               m_a = 0; m_disp = 0; m_cnt = 0;
            end else if (m_state == S_B) begin
               m_b = 0; m_disp = 0; m_cnt = 0;
            end
         end
      end
   endtask

   task automatic step(input bit kv, input int kc, input bit dm, input bit done, input int res);
      @(negedge clk);
      key_valid  = kv;
      key_code   = 5'(kc);
      dec_mode   = dm;
      alu_done   = done;
      alu_result = 16'(res);
      @(posedge clk);
      model_cycle(kv, kc, dm, done, res);
      #1;
      key_valid = 1'b0;
      alu_done  = 1'b0;
   endtask

   task automatic press(input int kc, input bit dm);
      step(1'b1, kc, dm, 1'b0, 0);
   endtask

   task automatic idle();
      step(1'b0, 0, dec_mode, 1'b0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (disp_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", disp_state); end
      vectors++; if (op_a !== 16'h0 || op_b !== 16'h0) begin miscompares++; $display("FAIL rst_ops: got %h/%h want 0/0", op_a, op_b); end
      vectors++; if (disp_val !== 16'h0) begin miscompares++; $display("FAIL rst_disp: got %h want 0", disp_val); end
      vectors++; if (alu_op !== 3'd0 || alu_start !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_ctl: got op=%0d start=%b err=%b want 0/0/0", alu_op, alu_start, err); end
      @(negedge clk);
      rst = 1'b1;
      dec_mode = 1'b1;
      #1;
      vectors++; if (restriction !== 1'b1) begin miscompares++; $display("FAIL restriction: got %b want 1", restriction); end
      dec_mode = 1'b0;
      #1;
      vectors++; if (restriction !== 1'b0) begin miscompares++; $display("FAIL restriction0: got %b want 0", restriction); end
   endtask

   task automatic test_async_reset();
      press(5, 1'b0);
      press(K_ADD, 1'b0);
      vectors++; if (op_a !== 16'h5 || disp_state !== 2'd1) begin miscompares++; $display("FAIL ar_pre: got a=%h st=%0d want 5/1", op_a, disp_state); end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++; if (op_a !== 16'h0 || disp_state !== 2'd0 || alu_op !== 3'd0) begin miscompares++; $display("FAIL ar_async: got a=%h st=%0d op=%0d want 0/0/0", op_a, disp_state, alu_op); end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_hex_entry();
      press(K_CLR, 1'b0);
      press(1, 1'b0); press(10, 1'b0); press(3, 1'b0); press(15, 1'b0); press(7, 1'b0);
      vectors++; if (op_a !== 16'h1A3F) begin miscompares++; $display("FAIL hex_op_a: got %h want 1a3f", op_a); end
      vectors++; if (disp_val !== 16'h1A3F || disp_state !== 2'd0) begin miscompares++; $display("FAIL hex_disp: got %h st=%0d want 1a3f/0", disp_val, disp_state); end
   endtask

   task automatic test_dec_sub();
      int starts;
      press(K_CLR, 1'b1);
      press(1, 1'b1); press(2, 1'b1); press(11, 1'b1);
      vectors++; if (op_a !== 16'd12) begin miscompares++; $display("FAIL dec_op_a: got %0d want 12", op_a); end
      press(K_SUB, 1'b1);
      press(5, 1'b1);
      vectors++; if (alu_op !== 3'd1 || op_b !== 16'd5 || disp_state !== 2'd1) begin miscompares++; $display("FAIL dec_sub: got op=%0d b=%0d st=%0d want 1/5/1", alu_op, op_b, disp_state); end
      press(K_EXE, 1'b1);
      starts = 0;
      if (alu_start === 1'b1) starts++;
      vectors++; if (disp_state !== 2'd2) begin miscompares++; $display("FAIL dec_wait: got %0d want 2", disp_state); end
      for (int i = 0; i < 3; i++) begin
         idle();
         if (alu_start === 1'b1) starts++;
      end
      vectors++; if (starts !== 1) begin miscompares++; $display("FAIL dec_start_cnt: got %0d want 1", starts); end
      step(1'b0, 0, 1'b1, 1'b1, 7);
      vectors++; if (disp_val !== 16'd7 || disp_state !== 2'd3) begin miscompares++; $display("FAIL dec_result: got %0d st=%0d want 7/3", disp_val, disp_state); end
   endtask

   task automatic test_ce();
      press(K_CLR, 1'b0);
      press(4, 1'b0); press(K_ADD, 1'b0); press(9, 1'b0); press(9, 1'b0);
      press(K_CE, 1'b0); press(3, 1'b0);
      vectors++; if (op_b !== 16'h3 || op_a !== 16'h4 || disp_state !== 2'd1) begin miscompares++; $display("FAIL ce: got a=%h b=%h st=%0d want 4/3/1", op_a, op_b, disp_state); end
   endtask

   task automatic test_timeout();
      press(K_EXE, 1'b0);
      for (int i = 0; i < ALU_TIMEOUT - 1; i++) idle();
      vectors++; if (err !== 1'b0 || disp_state !== 2'd2) begin miscompares++; $display("FAIL to_early: got err=%b st=%0d want 0/2", err, disp_state); end
      idle();
      vectors++; if (err !== 1'b1 || disp_val !== 16'hFFFF || disp_state !== 2'd3) begin miscompares++; $display("FAIL to_fire: got err=%b disp=%h st=%0d want 1/ffff/3", err, disp_val, disp_state); end
      press(5, 1'b0);
      vectors++; if (err !== 1'b0 || op_a !== 16'h5 || op_b !== 16'h0 || disp_state !== 2'd0) begin miscompares++; $display("FAIL to_clear: got err=%b a=%h b=%h st=%0d want 0/5/0/0", err, op_a, op_b, disp_state); end
   endtask

   task automatic test_clr_wait();
      press(K_CLR, 1'b0);
      press(1, 1'b0); press(K_ADD, 1'b0); press(2, 1'b0); press(K_EXE, 1'b0);
      idle();
      press(K_CLR, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 16'h1234);
      vectors++; if (disp_state !== 2'd0 || disp_val !== 16'h0 || op_a !== 16'h0 || op_b !== 16'h0) begin miscompares++; $display("FAIL clr_wait: got st=%0d disp=%h a=%h b=%h want 0/0/0/0", disp_state, disp_val, op_a, op_b); end
   endtask

   task automatic test_coincident();
      press(K_CLR, 1'b0);
      press(2, 1'b0); press(K_OR, 1'b0); press(3, 1'b0); press(K_EXE, 1'b0);
      step(1'b1, 9, 1'b0, 1'b1, 16'hBEEF);
      vectors++; if (disp_val !== 16'hBEEF || disp_state !== 2'd3 || op_a !== 16'h2) begin miscompares++; $display("FAIL co_key: got disp=%h st=%0d a=%h want beef/3/2", disp_val, disp_state, op_a); end
      press(K_CLR, 1'b0);
      press(2, 1'b0); press(K_OR, 1'b0); press(K_EXE, 1'b0);
      step(1'b1, K_CLR, 1'b0, 1'b1, 16'h5555);
      vectors++; if (disp_val !== 16'h0 || disp_state !== 2'd0) begin miscompares++; $display("FAIL co_clr: got disp=%h st=%0d want 0/0", disp_val, disp_state); end
   endtask

   task automatic test_chain();
      press(K_CLR, 1'b0);
      press(1, 1'b0); press(K_ADD, 1'b0); press(2, 1'b0); press(K_EXE, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 16'h0010);
      vectors++; if (disp_val !== 16'h0010 || disp_state !== 2'd3) begin miscompares++; $display("FAIL ch_result: got %h st=%0d want 0010/3", disp_val, disp_state); end
      press(K_MUL, 1'b0);
      press(2, 1'b0);
`ifdef CALC_CHAIN_EN
      vectors++; if (op_a !== 16'h0010 || op_b !== 16'h2 || alu_op !== 3'd2 || disp_state !== 2'd1) begin miscompares++; $display("FAIL chain_on: got a=%h b=%h op=%0d st=%0d want 0010/2/2/1", op_a, op_b, alu_op, disp_state); end
`else
      vectors++; if (op_a !== 16'h2 || op_b !== 16'h0 || alu_op !== 3'd0 || disp_state !== 2'd0) begin miscompares++; $display("FAIL chain_off: got a=%h b=%h op=%0d st=%0d want 2/0/0/0", op_a, op_b, alu_op, disp_state); end
`endif
   endtask

   task automatic test_random();
      logic [55:0] got, exp;
      press(K_CLR, 1'b0);
      for (int i = 0; i < 1200; i++) begin
         bit kv, done, dm;
         int kc, res;
         kv = ($urandom_range(0, 2) == 0);
         kc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 31));
         if (kc == K_CLR && $urandom_range(0, 3) != 0) kc = K_EXE;
         dm = ($urandom_range(0, 7) == 0) ? !dec_mode : dec_mode;
         done = (m_state == S_WAIT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         res = int'($urandom_range(0, 65535));
         step(kv, kc, dm, done, res);
         exp = {2'(m_state), 16'(m_a), 16'(m_b), 3'(m_op), m_start, 16'(m_disp), m_err, dec_mode};
         got = {disp_state, op_a, op_b, alu_op, alu_start, disp_val, err, restriction};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL rand[%0d]: got st=%0d a=%h b=%h op=%0d start=%b disp=%h err=%b; want st=%0d a=%h b=%h op=%0d start=%b disp=%h err=%b",
                     i, disp_state, op_a, op_b, alu_op, alu_start, disp_val, err,
                     m_state, m_a[15:0], m_b[15:0], m_op, m_start, m_disp[15:0], m_err);
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_async_reset();
      test_hex_entry();
      test_dec_sub();
      test_ce();
      test_timeout();
      test_clr_wait();
      test_coincident();
      test_chain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
